// File: rtl/rc5_key_expand.sv
// RC5-32/12/16 key schedule: captures a 16-byte key, builds the 26-word S table
// in registers and pulses oDone when S is valid. S is readable combinationally.
module rc5_key_expand #(
    parameter int          W  = 32,
    parameter int          B  = 16,
    parameter int          R  = 12,
    parameter logic [31:0] PW = 32'hB7E15163,
    parameter logic [31:0] QW = 32'h9E3779B9
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           iStart,
    input  logic [8*B-1:0]                 iKey,
    input  logic [$clog2(2*(R+1))-1:0]     iS_addr,
    output logic [W-1:0]                   oS_data,
    output logic                           oBusy,
    output logic                           oDone
);
    localparam int T    = 2 * (R + 1);
    localparam int C    = B * 8 / W;
    localparam int NMIX = 3 * ((T > C) ? T : C);
    localparam int IW   = $clog2(T);
    localparam int JW   = (C > 1) ? $clog2(C) : 1;
    localparam int KW   = $clog2(NMIX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_MIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    s_q [T];
    logic [W-1:0]    s_d [T];
    logic [W-1:0]    l_q [C];
    logic [W-1:0]    l_d [C];
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [IW-1:0]   i_q, i_d;
    logic [JW-1:0]   j_q, j_d;
    logic [KW-1:0]   k_q, k_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic [W-1:0]    init_val_s, mix_a_s, mix_ab_s, mix_b_s, rd_sel_s;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [4:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    // Next-state, S/L table update and key-schedule datapath
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        l_d     = l_q;
        a_d     = a_q;
        b_d     = b_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        // During INIT, A carries S[i-1] so each entry is one adder away
        init_val_s = (i_q == IW'(0)) ? PW : (a_q + QW);
        // b uses the freshly computed a, not the registered A
        mix_a_s  = rotl(s_q[i_q] + a_q + b_q, 5'd3);
        mix_ab_s = mix_a_s + b_q;
        mix_b_s  = rotl(l_q[j_q] + mix_ab_s, mix_ab_s[4:0]);

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    for (int n = 0; n < C; n++) begin
                        l_d[n] = iKey[W*n +: W];
                    end
                    i_d     = IW'(0);
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                s_d[i_q] = init_val_s;
                a_d      = init_val_s;
                if (i_q == IW'(T - 1)) begin
                    a_d     = '0;
                    b_d     = '0;
                    i_d     = IW'(0);
                    j_d     = JW'(0);
                    k_d     = KW'(0);
                    state_d = ST_MIX;
                end else begin
                    i_d     = i_q + IW'(1);
                end
            end
            ST_MIX: begin
                s_d[i_q] = mix_a_s;
                a_d      = mix_a_s;
                l_d[j_q] = mix_b_s;
                b_d      = mix_b_s;
                i_d      = (i_q == IW'(T - 1)) ? IW'(0) : (i_q + IW'(1));
                j_d      = (j_q == JW'(C - 1)) ? JW'(0) : (j_q + JW'(1));
                k_d      = k_q + KW'(1);
                if (k_q == KW'(NMIX - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MIX;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_INIT) || (state_d == ST_MIX);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            for (int n = 0; n < T; n++) begin
                s_q[n] <= '0;
            end
            for (int n = 0; n < C; n++) begin
                l_q[n] <= '0;
            end
            a_q    <= '0;
            b_q    <= '0;
            i_q    <= IW'(0);
            j_q    <= JW'(0);
            k_q    <= KW'(0);
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            l_q     <= l_d;
            a_q     <= a_d;
            b_q     <= b_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // AND-OR read mux; out-of-range addresses select nothing and return 0
    always_comb begin
        rd_sel_s = '0;
        for (int n = 0; n < T; n++) begin
            rd_sel_s = rd_sel_s | ({W{iS_addr == IW'(n)}} & s_q[n]);
        end
        oS_data = rd_sel_s;
    end

    assign oBusy = busy_q;
    assign oDone = done_q;

endmodule

// File: tb/tb_rc5_key_expand.sv
// Self-checking bench for rc5_key_expand: scoreboard of model S tables, latency and
// pulse checks, and RC5 decryption of known test vectors using the DUT's S table.
module tb_rc5_key_expand;
    logic         clk = 1'b0;
    logic         rst;
    logic         iStart;
    logic [127:0] iKey;
    logic [4:0]   iS_addr;
    logic [31:0]  oS_data;
    logic         oBusy;
    logic         oDone;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [31:0]  exp_q [$];
    logic [31:0]  mdl_s [26];
    logic [31:0]  dut_s [26];

    localparam logic [127:0] KEY_VEC = 128'h91CEA91001A5556351B241BE19465F91;
    localparam logic [127:0] KEY_2   = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] KEY_3   = 128'hDEADBEEF00C0FFEE1234567855AA33CC;
    localparam logic [127:0] KEY_4   = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] KEY_5   = 128'hFFFFFFFF000000010000000180000000;

    always #5 clk = ~clk;

    rc5_key_expand dut (
        .clk     (clk),
        .rst     (rst),
        .iStart  (iStart),
        .iKey    (iKey),
        .iS_addr (iS_addr),
        .oS_data (oS_data),
        .oBusy   (oBusy),
        .oDone   (oDone)
    );

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x >> m) | (x << (32 - m));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference RC5 key schedule
    task automatic build_model(input logic [127:0] key);
        logic [31:0] l [4];
        logic [31:0] a, b;
        int i, j;
        for (int n = 0; n < 4; n++) l[n] = key[32*n +: 32];
        mdl_s[0] = 32'hB7E15163;
        for (int n = 1; n < 26; n++) mdl_s[n] = mdl_s[n-1] + 32'h9E3779B9;
        a = 32'd0; b = 32'd0; i = 0; j = 0;
        for (int k = 0; k < 78; k++) begin
            a = rotl32(mdl_s[i] + a + b, 3);
            mdl_s[i] = a;
            b = rotl32(l[j] + a + b, int'((a + b) & 32'd31));
            l[j] = b;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    task automatic push_model(input logic [127:0] key);
        build_model(key);
        for (int n = 0; n < 26; n++) exp_q.push_back(mdl_s[n]);
    endtask

    task automatic rd(input int addr, output logic [31:0] d);
        iS_addr = addr[4:0];
        #1;
        d = oS_data;
    endtask

    task automatic sb_check(input string tag);
        logic [31:0] obs, expv;
        for (int n = 0; n < 26; n++) begin
            if (exp_q.size() == 0) begin
                check($sformatf("%s_sb_empty[%0d]", tag, n), 32'd1, 32'd0);
            end else begin
                expv = exp_q.pop_front();
                rd(n, obs);
                check($sformatf("%s[%0d]", tag, n), obs, expv);
            end
        end
    endtask

    task automatic decrypt_check(input string tag, input logic [31:0] ca, input logic [31:0] cb,
                                 input logic [31:0] pa, input logic [31:0] pb);
        logic [31:0] a, b;
        for (int n = 0; n < 26; n++) rd(n, dut_s[n]);
        a = ca; b = cb;
        for (int r = 12; r >= 1; r--) begin
            b = rotr32(b - dut_s[2*r+1], int'(a & 32'd31)) ^ a;
            a = rotr32(a - dut_s[2*r], int'(b & 32'd31)) ^ b;
        end
        b = b - dut_s[1];
        a = a - dut_s[0];
        check({tag, "_A"}, a, pa);
        check({tag, "_B"}, b, pb);
    endtask

    // kind: 0 plain, 1 INIT snapshot at ev, 2 reset at ev, 3 stray start with alt_key at ev
    task automatic run(input logic [127:0] key, input logic [127:0] alt_key, input bit hold,
                       input int kind, input int ev, input int n_edges,
                       output int done_edge, output int done_cnt, output int busy_cnt);
        logic [31:0] obs;
        done_edge = -1; done_cnt = 0; busy_cnt = 0;
        for (int e = 0; e < n_edges; e++) begin
            rst    = (kind == 2) && (e == ev);
            iStart = (e == 0) || hold || ((kind == 3) && (e == ev));
            if (e == 0) iKey = key;
            if ((kind == 3) && (e == ev)) iKey = alt_key;
            @(posedge clk);
            @(negedge clk);
            if (oBusy) busy_cnt++;
            if (oDone) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e + 1;
            end
            if ((kind == 1) && (e == ev)) begin
                rd(0, obs);  check("init_s0", obs, 32'hB7E15163);
                rd(1, obs);  check("init_s1", obs, 32'h5618CB1C);
                rd(25, obs); check("init_s25", obs, 32'h2B4C3474);
            end
            if ((kind == 2) && (e == ev)) begin
                check("rst_mix_busy", 32'(oBusy), 32'd0);
                check("rst_mix_done", 32'(oDone), 32'd0);
                rd(0, obs); check("rst_mix_s0", obs, 32'd0);
            end
        end
        rst    = 1'b0;
        iStart = 1'b0;
    endtask

    initial begin
        int de, dc, bc;
        logic [31:0] obs;

        rst = 1'b1; iStart = 1'b0; iKey = '0; iS_addr = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(oBusy), 32'd0);
        check("reset_done", 32'(oDone), 32'd0);
        rd(0, obs);  check("reset_s0", obs, 32'd0);
        rd(25, obs); check("reset_s25", obs, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero key: INIT snapshot, pulse timing, busy length, full S and decryption
        push_model(128'd0);
        run(128'd0, 128'd0, 1'b0, 1, 26, 130, de, dc, bc);
        check("zero_done_edge", 32'(de), 32'd105);
        check("zero_done_cnt", 32'(dc), 32'd1);
        check("zero_busy_cycles", 32'(bc), 32'd104);
        sb_check("zero_s");
        decrypt_check("zero_dec", 32'hEEDBA521, 32'h6D8F4B15, 32'h00000000, 32'h00000000);

        // Published test-vector key
        push_model(KEY_VEC);
        run(KEY_VEC, 128'd0, 1'b0, 0, 0, 130, de, dc, bc);
        check("vec_done_edge", 32'(de), 32'd105);
        sb_check("vec_s");
        decrypt_check("vec_dec", 32'hAC13C0F7, 32'h52892B5B, 32'hEEDBA521, 32'h6D8F4B15);

        // Reset mid-MIX abandons the run; a fresh start completes normally
        run(KEY_2, 128'd0, 1'b0, 2, 50, 70, de, dc, bc);
        check("rst_mix_no_done", 32'(dc), 32'd0);
        push_model(KEY_2);
        run(KEY_2, 128'd0, 1'b0, 0, 0, 130, de, dc, bc);
        check("after_rst_done_edge", 32'(de), 32'd105);
        check("after_rst_done_cnt", 32'(dc), 32'd1);
        sb_check("after_rst_s");

        // iStart held high: one pulse per run, restart only from IDLE
        run(KEY_VEC, 128'd0, 1'b1, 0, 0, 215, de, dc, bc);
        check("hold_first_done", 32'(de), 32'd105);
        check("hold_done_cnt", 32'(dc), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Stray start with another key during MIX is ignored
        push_model(KEY_3);
        run(KEY_3, ~KEY_3, 1'b0, 3, 40, 130, de, dc, bc);
        check("stray_done_edge", 32'(de), 32'd105);
        check("stray_done_cnt", 32'(dc), 32'd1);
        sb_check("stray_s");

        for (int a = 26; a < 32; a++) begin
            rd(a, obs);
            check($sformatf("oor_%0d", a), obs, 32'd0);
        end

        // Back-to-back runs: second start lands on the first IDLE edge
        run(KEY_4, 128'd0, 1'b0, 0, 0, 106, de, dc, bc);
        check("b2b_first_done", 32'(de), 32'd105);
        push_model(KEY_5);
        run(KEY_5, 128'd0, 1'b0, 0, 0, 130, de, dc, bc);
        check("b2b_second_done", 32'(de), 32'd105);
        sb_check("b2b_s");
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
